sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/sensor_pkg.sv | 16 +
 rtl/sync_2ff.sv | 26 ++
 rtl/sensor_conditioner.sv | 144 ++++++++++++++
 tb/tb_sensor_conditioner.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared types and defaults for the vehicle-loop sensor conditioner.
package sensor_pkg;

    // Debounce FSM states: the two *_WAIT states hold the previous accepted level
    // while the opposite level is being qualified.
    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } deb_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 8;
    localparam int COUNT_W_DEF         = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pad input.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    // Shift the pad level through two flops to settle metastability.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: flops are written with <= so both stages sample the old values on the same edge.
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Vehicle-loop sensor conditioner: synchronises and debounces the loop input,
// raises a sticky request per accepted arrival and counts arrivals.
// Optional macro SENSOR_COUNT_EN builds the saturating arrival counter; when it is
// undefined veh_count and count_sat are tied low.
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int COUNT_W         = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sensor_raw,
    input  logic               req_ack,
    output logic               sensor_clean,
    output logic               sensor_req,
    output logic [COUNT_W-1:0] veh_count,
    output logic               count_sat
);

    // Stable-count value at which the pending level is accepted.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       s2;
    deb_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sensor_clean_q, sensor_clean_d;
    logic       sensor_req_q, sensor_req_d;
    logic       arrival;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sensor_raw),
        .q     (s2)
    );

    // Debounce next-state logic: qualify a level change over DEBOUNCE_CYCLES stable cycles.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_LOW: begin
                if (s2) begin
                    state_d = ST_RISE_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            ST_RISE_WAIT: begin
                if (!s2) begin
                    state_d = ST_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (!s2) begin
                    state_d = ST_FALL_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            ST_FALL_WAIT: begin
                if (s2) begin
                    state_d = ST_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // An arrival is the single RISE_WAIT->HIGH acceptance of a rising level.
    assign arrival = (state_q == ST_RISE_WAIT) && (state_d == ST_HIGH);

    // Clean level follows the accepted level held by the next state; request is sticky,
    // and a simultaneous arrival overrides the acknowledge.
    always_comb begin
        sensor_clean_d = (state_d == ST_HIGH) || (state_d == ST_FALL_WAIT);
        sensor_req_d   = sensor_req_q;
        if (req_ack) begin
            sensor_req_d = 1'b0;
        end
        if (arrival) begin
            sensor_req_d = 1'b1;
        end
    end

    // State, stable counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_LOW;
            cnt_q          <= 8'd0;
            sensor_clean_q <= 1'b0;
            sensor_req_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sensor_clean_q <= sensor_clean_d;
            sensor_req_q   <= sensor_req_d;
        end
    end

    assign sensor_clean = sensor_clean_q;
    assign sensor_req   = sensor_req_q;

`ifdef SENSOR_COUNT_EN
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [COUNT_W-1:0] veh_count_q, veh_count_d;

    // Saturating arrival count: hold at all-ones rather than wrap.
    always_comb begin
        veh_count_d = veh_count_q;
        if (arrival && (veh_count_q != COUNT_MAX)) begin
            veh_count_d = veh_count_q + 1'b1;
        end
    end

    // Arrival counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            veh_count_q <= '0;
        end else begin
            veh_count_q <= veh_count_d;
        end
    end

    assign veh_count = veh_count_q;
    assign count_sat = (veh_count_q == COUNT_MAX);
`else
    assign veh_count = '0;
    assign count_sat = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed testbench for sensor_conditioner (DEBOUNCE_CYCLES=8, COUNT_W=2).
// Expected counter values follow SENSOR_COUNT_EN: counted when defined, zero otherwise.
module tb_sensor_conditioner;

    localparam int D   = 8;
    localparam int CW  = 2;
    // Edges after the first high sample before sensor_clean changes.
    localparam int LAT = D + 2;
`ifdef SENSOR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          sensor_raw;
    logic          req_ack;
    logic          sensor_clean;
    logic          sensor_req;
    logic [CW-1:0] veh_count;
    logic          count_sat;

    int n_vec = 0;
    int n_bad = 0;
    int n_arr = 0;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .COUNT_W         (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sensor_raw   (sensor_raw),
        .req_ack      (req_ack),
        .sensor_clean (sensor_clean),
        .sensor_req   (sensor_req),
        .veh_count    (veh_count),
        .count_sat    (count_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        if (!CNT_EN) return 32'd0;
        return (n > 3) ? 32'd3 : 32'(n);
    endfunction

    function automatic logic [31:0] exp_sat(input int n);
        return (CNT_EN && n >= 3) ? 32'd1 : 32'd0;
    endfunction

    task automatic check_count(input string tag);
        check({tag, "_cnt"}, 32'(veh_count), exp_cnt(n_arr));
        check({tag, "_sat"}, 32'(count_sat), exp_sat(n_arr));
    endtask

    initial begin
        int glitch_len[3];
        glitch_len[0] = 1;
        glitch_len[1] = 4;
        glitch_len[2] = 7;

        // Reset state
        reset      = 1'b1;
        sensor_raw = 1'b0;
        req_ack    = 1'b0;
        tick(3);
        check("rst_clean", 32'(sensor_clean), 32'd0);
        check("rst_req", 32'(sensor_req), 32'd0);
        check_count("rst");
        reset = 1'b0;
        tick(2);

        // Held-high input: clean and request rise exactly LAT edges after the first sample
        sensor_raw = 1'b1;
        tick(LAT);
        check("rise_early_clean", 32'(sensor_clean), 32'd0);
        check("rise_early_req", 32'(sensor_req), 32'd0);
        tick(1);
        n_arr++;
        check("rise_clean", 32'(sensor_clean), 32'd1);
        check("rise_req", 32'(sensor_req), 32'd1);
        check_count("rise");

        // Falling edge has the same latency; request stays sticky
        sensor_raw = 1'b0;
        tick(LAT);
        check("fall_early_clean", 32'(sensor_clean), 32'd1);
        tick(1);
        check("fall_clean", 32'(sensor_clean), 32'd0);
        check("fall_req_sticky", 32'(sensor_req), 32'd1);

        // Acknowledge clears; a second acknowledge with nothing pending does nothing
        req_ack = 1'b1;
        tick(1);
        req_ack = 1'b0;
        check("ack_clear", 32'(sensor_req), 32'd0);
        req_ack = 1'b1;
        tick(1);
        req_ack = 1'b0;
        check("ack_idle", 32'(sensor_req), 32'd0);
        check_count("ack_idle");

        // Short glitches are rejected
        foreach (glitch_len[g]) begin
            sensor_raw = 1'b1;
            tick(glitch_len[g]);
            sensor_raw = 1'b0;
            tick(3);
            check($sformatf("glitch%0d_mid_clean", glitch_len[g]), 32'(sensor_clean), 32'd0);
            tick(LAT);
            check($sformatf("glitch%0d_clean", glitch_len[g]), 32'(sensor_clean), 32'd0);
            check($sformatf("glitch%0d_req", glitch_len[g]), 32'(sensor_req), 32'd0);
            check_count($sformatf("glitch%0d", glitch_len[g]));
        end

        // Arrival coincident with acknowledge: set wins; next acknowledge clears
        sensor_raw = 1'b1;
        tick(LAT);
        req_ack = 1'b1;
        tick(1);
        req_ack = 1'b0;
        n_arr++;
        check("coinc_clean", 32'(sensor_clean), 32'd1);
        check("coinc_req", 32'(sensor_req), 32'd1);
        check_count("coinc");
        req_ack = 1'b1;
        tick(1);
        req_ack = 1'b0;
        check("coinc_ack_next", 32'(sensor_req), 32'd0);

        // Short dropout while high: level held, no new arrival
        sensor_raw = 1'b0;
        tick(3);
        sensor_raw = 1'b1;
        tick(3);
        check("dip_mid_clean", 32'(sensor_clean), 32'd1);
        tick(LAT);
        check("dip_clean", 32'(sensor_clean), 32'd1);
        check("dip_req", 32'(sensor_req), 32'd0);
        check_count("dip");

        // Three more arrivals drive a 2-bit counter into saturation
        for (int a = 3; a <= 5; a++) begin
            sensor_raw = 1'b0;
            tick(LAT + 1);
            check($sformatf("arr%0d_low", a), 32'(sensor_clean), 32'd0);
            sensor_raw = 1'b1;
            tick(LAT + 1);
            n_arr++;
            check($sformatf("arr%0d_clean", a), 32'(sensor_clean), 32'd1);
            check_count($sformatf("arr%0d", a));
        end
        check("sat_req", 32'(sensor_req), 32'd1);

        // Asynchronous reset in RISE_WAIT with cnt=5 discards all progress
        sensor_raw = 1'b0;
        tick(LAT + 1);
        sensor_raw = 1'b1;
        tick(8);
        #3;
        reset = 1'b1;
        #1;
        n_arr = 0;
        check("arst_clean", 32'(sensor_clean), 32'd0);
        check("arst_req", 32'(sensor_req), 32'd0);
        check_count("arst");
        #2;
        reset = 1'b0;
        tick(LAT);
        check("arst_relat_early", 32'(sensor_clean), 32'd0);
        check("arst_relat_early_req", 32'(sensor_req), 32'd0);
        tick(1);
        n_arr++;
        check("arst_relat_clean", 32'(sensor_clean), 32'd1);
        check("arst_relat_req", 32'(sensor_req), 32'd1);
        check_count("arst_relat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
